// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
//   state_t   : sequencing states of the serial datapath (IDLE, SHIFT, FIN)
//   DEFAULT_N : default operand/result width
package serial_arith_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      FIN   = 2'd2
   } state_t;

   localparam int DEFAULT_N = 8;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell, purely combinational.
// Ports:
//   X, Y  : minuend and subtrahend bits
//   BIN   : borrow in from the less significant bit
//   D     : difference bit  X - Y - BIN
//   BOUT  : borrow out to the more significant bit
module full_subtractor (
   input  logic X,
   input  logic Y,
   input  logic BIN,
   output logic D,
   output logic BOUT
);

   assign D = X ^ Y ^ BIN;

   // Borrow when y exceeds x outright, or when x and y are equal and a
   // borrow is already pending from below.
   assign BOUT = (~X & Y) | (~(X ^ Y) & BIN);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor, D = X - Y, one bit per clock, LSB first.
// Ports:
//   CLK   : rising-edge clock
//   RST_N : asynchronous active-low reset
//   START : request, sampled only while idle
//   X, Y  : minuend / subtrahend, captured on the accepting edge
//   BUSY  : high while the N shift cycles are in progress
//   DONE  : one-cycle pulse, result valid
//   D     : difference X - Y mod 2^N, held until the next DONE
//   B     : borrow out, 1 iff X < Y (unsigned)
module serial_subtractor
   import serial_arith_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic         CLK,
   input  logic         RST_N,
   input  logic         START,
   input  logic [N-1:0] X,
   input  logic [N-1:0] Y,
   output logic         BUSY,
   output logic         DONE,
   output logic [N-1:0] D,
   output logic         B
);

   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

   state_t         state_reg;
   state_t         state_next;
   logic [N-1:0]   xs_reg;
   logic [N-1:0]   ys_reg;
   logic [N-1:0]   rs_reg;
   logic           br_reg;
   logic [CW-1:0]  cnt_reg;
   logic [N-1:0]   d_reg;
   logic           b_reg;
   logic           busy_reg;
   logic           done_reg;

   logic           accept;
   logic           shift_en;
   logic           last_bit;
   logic           busy_next;
   logic           done_next;
   logic           cell_d;
   logic           cell_bout;
   logic [N-1:0]   rs_shifted;

   full_subtractor u_cell (
      .X    (xs_reg[0]),
      .Y    (ys_reg[0]),
      .BIN  (br_reg),
      .D    (cell_d),
      .BOUT (cell_bout)
   );

   assign last_bit   = (cnt_reg == LAST_CNT);
   // New difference bit enters at the top; after N shifts bit 0 sits at the LSB.
   assign rs_shifted = {cell_d, rs_reg[N-1:1]};

   // ---------------------------------------------------------------------
   // FSM
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      shift_en   = 1'b0;
      case (state_reg)
         IDLE: begin
            if (START) begin
               accept     = 1'b1;
               state_next = SHIFT;
            end
         end
         SHIFT: begin
            shift_en = 1'b1;
            if (last_bit) begin
               state_next = FIN;
            end
         end
         FIN: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
      // Status flags are registered from the next state so they line up
      // with the state they describe and never depend on START combinationally.
      busy_next = (state_next == SHIFT);
      done_next = (state_next == FIN);
   end

   // ---------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         xs_reg   <= '0;
         ys_reg   <= '0;
         rs_reg   <= '0;
         br_reg   <= 1'b0;
         cnt_reg  <= '0;
         d_reg    <= '0;
         b_reg    <= 1'b0;
         busy_reg <= 1'b0;
         done_reg <= 1'b0;
      end else begin
         busy_reg <= busy_next;
         done_reg <= done_next;
         if (accept) begin
            xs_reg  <= X;
            ys_reg  <= Y;
            rs_reg  <= '0;
            br_reg  <= 1'b0;
            cnt_reg <= '0;
         end else if (shift_en) begin
            xs_reg <= xs_reg >> 1;
            ys_reg <= ys_reg >> 1;
            rs_reg <= rs_shifted;
            br_reg <= cell_bout;
            if (last_bit) begin
               // Park the counter at zero instead of letting it wrap.
               cnt_reg <= '0;
               d_reg   <= rs_shifted;
               b_reg   <= cell_bout;
            end else begin
               cnt_reg <= cnt_reg + CW'(1);
            end
         end
      end
   end

   assign BUSY = busy_reg;
   assign DONE = done_reg;
   assign D    = d_reg;
   assign B    = b_reg;

endmodule

// File: doc/serial_subtractor.md
# serial_subtractor

Bit-serial N-bit subtractor computing D = X − Y one bit per clock, LSB first, with a registered borrow chain. It is the inverse-operation companion of the team's combinational adder cells, built from a one-bit full-subtractor cell. It trades N cycles of latency for a single-bit datapath and is driven by a START/DONE handshake, so a sequencing block or a testbench can issue operations back to back.

## Interface
- N, default 8, operand and result width; legal range 2..32.
- CLK  input  1  rising-edge clock.
- RST_N  input  1  asynchronous active-low reset.
- START  input  1  request; sampled only in IDLE.
- X  input  N  minuend; captured on the accepting edge.
- Y  input  N  subtrahend; captured on the accepting edge.
- BUSY  output  1  high while an operation is in progress.
- DONE  output  1  single-cycle pulse marking that the result is valid.
- D  output  N  difference X − Y mod 2^N; holds until the next DONE.
- B  output  1  borrow out; 1 iff X < Y as unsigned values.

## Operation
- States: IDLE, SHIFT, FIN.
- IDLE with START=1:
  - capture X into shift register XS and Y into YS;
  - clear borrow flop BR and bit counter CNT;
  - go to SHIFT.
- IDLE with START=0: stay in IDLE.
- SHIFT, on each edge:
  - the bit cell takes x=XS[0], y=YS[0], bin=BR;
  - d = x^y^bin, bout = (~x&y) | (~(x^y)&bin);
  - d shifts into the MSB of the result register RS, and RS shifts right;
  - XS and YS shift right;
  - BR <= bout;
  - CNT <= CNT+1.
- SHIFT to FIN on the edge that processes bit N−1 (CNT == N−1).
- On that same edge, D <= the final RS contents and B <= bout. D/B change only on this edge.
- FIN: DONE=1 for exactly one cycle, then unconditionally back to IDLE.
- START is ignored in SHIFT and FIN. No queuing, and operands are not re-sampled.
- X/Y may change freely after the accepting edge without affecting the result.
- Arithmetic is unsigned. Signed interpretation is left to the consumer: D is the correct two's-complement result, and B is not a signed-overflow flag.
- RST_N low at any time, including mid-SHIFT:
  - immediately go to IDLE;
  - D=0, B=0, DONE=0, BUSY=0;
  - clear XS, YS, RS, BR and CNT;
  - the partial result is discarded.

## Timing
- Reset values: BUSY=0, DONE=0, D=0, B=0, state IDLE.
- Accepting edge is edge 0:
  - BUSY=1 in the cycles following edges 0..N−1;
  - DONE=1 and D/B valid in the cycle following edge N.
- Latency from START sampled to DONE high is N+1 cycles after the accepting edge's cycle. There are N SHIFT edges.
- BUSY and DONE are never high together. BUSY drops in the same cycle DONE rises.
- Back-to-back throughput: START held high is accepted again on the edge where FIN returns to IDLE+1. The operation period is N+2 cycles.
- DONE and BUSY are registered, with no combinational path from START.
- CNT width is clog2(N). The counter must not wrap during an operation.

## Structure
- Shared package serial_arith_pkg holds:
  - the state encoding constants (IDLE=2'd0, SHIFT=2'd1, FIN=2'd2);
  - the default width constant.
- Sub-module full_subtractor, purely combinational:
  - ports X, Y, BIN, D, BOUT;
  - instantiated once for the bit cell;
  - independently testable, exhaustively over all 8 input combinations.
- Top level contains the FSM, CNT, the XS/YS/RS shift registers, BR, and the output registers.

## Test plan
- N=8, X=0x5A, Y=0x33, START pulse: DONE one cycle, exactly 9 cycles after the accepting edge; D=0x27, B=0; BUSY high for 8 cycles.
- X=0x10, Y=0x20: D=0xF0, B=1.
- X=0x00, Y=0x00 gives D=0x00, B=0. X=0xFF, Y=0xFF gives D=0x00, B=0. X=0x00, Y=0x01 gives D=0xFF, B=1.
- START re-pulsed mid-SHIFT with different X/Y: ignored, and the original result is delivered unchanged. START held high continuously: consecutive DONE pulses 10 cycles apart.
- RST_N asserted 4 cycles into SHIFT (asynchronously, between edges):
  - BUSY/DONE/D/B go to 0 immediately;
  - no DONE appears after release;
  - the next operation 0x05−0x03 gives D=0x02, B=0.
- full_subtractor unit check, all 8 combos of (X,Y,BIN): D = X^Y^BIN; BOUT = 1 exactly for 010, 011, 001, 111.
